right_rotator_seq: RTL and testbench

- Sequential right rotator. Accepts a WIDTH-bit word and a rotate amount, then rotates it right by one bit per clock. It returns the result with a one-cycle done pulse.
- Companion to the combinational left rotator in the multi-barrel rotator group. Serves low-area datapaths where multi-cycle latency is acceptable.
- Uses a start/busy/done handshake so a controller FSM can sequence operations.

---
 rtl/right_rotator_seq.sv | 128 ++++++++++++
 tb/tb_right_rotator_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/right_rotator_seq.sv
// Sequential rotator: rotates one bit position per clock behind a start/busy/done handshake.
// Optional macro RROT_DIR_SEL_EN adds a dir port (0 = right, 1 = left).
module right_rotator_seq #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] d_in,
    input  logic [AMT_W-1:0] bit_amount,
`ifdef RROT_DIR_SEL_EN
    input  logic             dir,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d_out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROTATE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] shift_nxt_s;
    logic [WIDTH-1:0] dout_r;
    logic [WIDTH-1:0] dout_nxt_s;
    logic [WIDTH-1:0] rot_s;
    logic [AMT_W-1:0] cnt_r;
    logic [AMT_W-1:0] cnt_nxt_s;
    logic             dir_r;
    logic             dir_nxt_s;
    logic             dir_in_s;
    logic             busy_r;
    logic             done_r;

    if (WIDTH < 2 || (1 << AMT_W) != WIDTH) begin : g_bad_param
        $error("right_rotator_seq: WIDTH must be a power of two >= 2 and equal 2**AMT_W");
    end

`ifdef RROT_DIR_SEL_EN
    assign dir_in_s = dir;
`else
    assign dir_in_s = 1'b0;
`endif

    // Single-position rotation of the working register in the captured direction
    always_comb begin
        if (dir_r) begin
            rot_s = {shift_r[WIDTH-2:0], shift_r[WIDTH-1]};
        end else begin
            rot_s = {shift_r[0], shift_r[WIDTH-1:1]};
        end
    end

    // Next-state and datapath decode; d_out only changes on the edge entering DONE
    always_comb begin
        state_nxt_s = state_r;
        shift_nxt_s = shift_r;
        cnt_nxt_s   = cnt_r;
        dir_nxt_s   = dir_r;
        dout_nxt_s  = dout_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    shift_nxt_s = d_in;
                    cnt_nxt_s   = bit_amount;
                    dir_nxt_s   = dir_in_s;
                    if (bit_amount != {AMT_W{1'b0}}) begin
                        state_nxt_s = ST_ROTATE;
                    end else begin
                        // Zero amount skips ROTATE so the counter never underflows
                        state_nxt_s = ST_DONE;
                        dout_nxt_s  = d_in;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ROTATE: begin
                shift_nxt_s = rot_s;
                cnt_nxt_s   = cnt_r - AMT_W'(1);
                if (cnt_r == AMT_W'(1)) begin
                    state_nxt_s = ST_DONE;
                    dout_nxt_s  = rot_s;
                end else begin
                    state_nxt_s = ST_ROTATE;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            shift_r <= {WIDTH{1'b0}};
            cnt_r   <= {AMT_W{1'b0}};
            dir_r   <= 1'b0;
            dout_r  <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            shift_r <= shift_nxt_s;
            cnt_r   <= cnt_nxt_s;
            dir_r   <= dir_nxt_s;
            dout_r  <= dout_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign d_out = dout_r;

endmodule

// File: tb/tb_right_rotator_seq.sv
// Scoreboard bench for right_rotator_seq: directed cases plus random start/operand traffic.
module tb_right_rotator_seq;

    localparam int WIDTH = 8;
    localparam int AMT_W = 3;
`ifdef RROT_DIR_SEL_EN
    localparam logic DIR_EN = 1'b1;
`else
    localparam logic DIR_EN = 1'b0;
`endif

    typedef struct {
        logic [WIDTH-1:0] data;
        int               done_cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] d_in;
    logic [AMT_W-1:0] bit_amount;
    logic             dir;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d_out;

    exp_t             q[$];
    int               cyc      = 0;
    int               free_cyc = 0;
    int               n_chk    = 0;
    int               n_fail   = 0;
    logic [WIDTH-1:0] last_exp = '0;

    right_rotator_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .d_in       (d_in),
        .bit_amount (bit_amount),
`ifdef RROT_DIR_SEL_EN
        .dir        (dir),
`endif
        .busy       (busy),
        .done       (done),
        .d_out      (d_out)
    );

    always #5 clk = ~clk;

    // Reference rotation: take the window of a doubled word
    function automatic logic [WIDTH-1:0] rot(input logic [WIDTH-1:0] d, input int n, input logic left);
        logic [2*WIDTH-1:0] dd;
        dd = {d, d};
        if (left) begin
            dd = dd << n;
            return dd[2*WIDTH-1:WIDTH];
        end else begin
            dd = dd >> n;
            return dd[WIDTH-1:0];
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: compares outputs against the scoreboard on every falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() != 0 && q[0].done_cyc < cyc) begin
                chk("done_missing", 32'(done), 32'(1));
                void'(q.pop_front());
            end
            if (q.size() != 0 && q[0].done_cyc == cyc) begin
                chk("done", 32'(done), 32'(1));
                chk("d_out", 32'(d_out), 32'(q[0].data));
                last_exp = q[0].data;
                void'(q.pop_front());
            end else begin
                chk("done_idle", 32'(done), 32'(0));
                chk("d_out_hold", 32'(d_out), 32'(last_exp));
            end
            chk("busy", 32'(busy), 32'(rst_n && (cyc < free_cyc)));
        end
    end

    // One cycle of stimulus; the model decides acceptance from its own idea of idle
    task automatic drive(input logic s, input logic [WIDTH-1:0] d, input logic [AMT_W-1:0] a, input logic dr);
        exp_t e;
        @(negedge clk);
        #1;
        start      = s;
        d_in       = d;
        bit_amount = a;
        dir        = dr & DIR_EN;
        if (s && rst_n && cyc >= free_cyc) begin
            e.data     = rot(d, int'(a), dir);
            e.done_cyc = cyc + int'(a) + 1;
            q.push_back(e);
            free_cyc = cyc + int'(a) + 2;
        end
    endtask

    task automatic op(input logic [WIDTH-1:0] d, input logic [AMT_W-1:0] a, input logic dr);
        int guard;
        guard = 0;
        while (cyc + 1 < free_cyc && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        drive(1'b1, d, a, dr);
        drive(1'b0, '0, '0, 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        q.delete();
        free_cyc = cyc;
        last_exp = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_d_out", 32'(d_out), 32'(0));
        repeat (cycles) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        start      = 1'b0;
        d_in       = '0;
        bit_amount = '0;
        dir        = 1'b0;
        rst_n      = 1'b1;
        #2;
        do_reset(2);
        repeat (3) drive(1'b0, '0, '0, 1'b0);

        op(8'hB4, 3'd3, 1'b0);
        op(8'hA5, 3'd0, 1'b0);
        op(8'h01, 3'd7, 1'b0);
        repeat (5) drive(1'b1, 8'hFF, AMT_W'($urandom), 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        op(8'hB4, 3'd3, 1'b1);
        op(8'hB4, 3'd3, 1'b0);

        op(8'h81, 3'd5, 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        do_reset(2);
        repeat (8) drive(1'b0, '0, '0, 1'b0);
        op(8'h81, 3'd1, 1'b0);

        repeat (120) begin
            drive(1'($urandom_range(0, 1)), WIDTH'($urandom), AMT_W'($urandom), 1'($urandom));
        end
        drive(1'b0, '0, '0, 1'b0);

        guard = 0;
        while (q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_timeout", 32'(q.size()), 32'(0));
        repeat (3) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
